// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared Avalon bus response codes, slave FSM states and default memory map
package mips_bus_pkg;
  typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11} resp_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_INSTR, SEL_DATA} sel_t;
  localparam logic [31:0] DEF_INSTR_BASE = 32'hBFC0_0000;
  localparam int DEF_INSTR_WORDS = 1024;
  localparam logic [31:0] DEF_DATA_BASE = 32'h0000_0000;
  localparam int DEF_DATA_WORDS = 4096;
endpackage

// File: rtl/mips_mem_addr_decode.sv
// mips_mem_addr_decode: maps a byte address to region select, word index and response code
module mips_mem_addr_decode import mips_bus_pkg::*; #(
  parameter logic [31:0] INSTR_BASE = DEF_INSTR_BASE,
  parameter int INSTR_WORDS = DEF_INSTR_WORDS,
  parameter logic [31:0] DATA_BASE = DEF_DATA_BASE,
  parameter int DATA_WORDS = DEF_DATA_WORDS,
  parameter int IW = 12
) (
  input  logic [31:0]   addr,
  output sel_t          sel,
  output logic [IW-1:0] idx,
  output resp_t         resp
);
  logic [30:0] ioff, doff;
  always_comb begin
    ioff = {1'b0, addr[31:2]} - {1'b0, INSTR_BASE[31:2]};
    doff = {1'b0, addr[31:2]} - {1'b0, DATA_BASE[31:2]};
    sel = (ioff < 31'(INSTR_WORDS)) ? SEL_INSTR : (doff < 31'(DATA_WORDS)) ? SEL_DATA : SEL_NONE;
    idx = sel == SEL_INSTR ? ioff[IW-1:0] : doff[IW-1:0];
    resp = sel == SEL_NONE ? RESP_DECERR : addr[1:0] != 2'b00 ? RESP_SLVERR : RESP_OKAY;
  end
endmodule

// File: rtl/mips_avalon_mem_wait.sv
// mips_avalon_mem_wait: Avalon-MM slave memory with instruction/data regions and wait states
// MIPS_MEM_RANDOM_WAIT_EN adds 0..3 LFSR-driven extra wait cycles per transfer.
module mips_avalon_mem_wait import mips_bus_pkg::*; #(
  parameter int WAIT_CYCLES = 2,
  parameter logic [31:0] INSTR_BASE = DEF_INSTR_BASE,
  parameter int INSTR_WORDS = DEF_INSTR_WORDS,
  parameter logic [31:0] DATA_BASE = DEF_DATA_BASE,
  parameter int DATA_WORDS = DEF_DATA_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [3:0]  byteenable,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic [1:0]  response
);
  localparam int IIW = $clog2(INSTR_WORDS);
  localparam int DIW = $clog2(DATA_WORDS);
  localparam int IW = IIW > DIW ? IIW : DIW;
  state_t state;
  logic [4:0] cnt, load;
  logic [31:0] lat_addr, lat_wdata, src_addr, rd_word;
  logic [3:0] lat_be;
  logic lat_rd, lat_wr, src_rd, src_wr, req, go_done, commit;
  logic [1:0] extra;
  sel_t sel;
  logic [IW-1:0] idx;
  resp_t dresp, tr_resp;
  logic [31:0] imem [INSTR_WORDS];
  logic [31:0] dmem [DATA_WORDS];
  mips_mem_addr_decode #(
    .INSTR_BASE(INSTR_BASE), .INSTR_WORDS(INSTR_WORDS),
    .DATA_BASE(DATA_BASE), .DATA_WORDS(DATA_WORDS), .IW(IW)
  ) u_dec (.addr(src_addr), .sel(sel), .idx(idx), .resp(dresp));
`ifdef MIPS_MEM_RANDOM_WAIT_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk or posedge reset)
    if (reset) lfsr <= 8'hA5;
    else if (state == ST_IDLE && req) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign extra = lfsr[1:0];
`else
  assign extra = 2'd0;
`endif
  // In IDLE the decoder looks at the live bus so a one-cycle transfer can still register readdata.
  always_comb begin
    req = read | write;
    src_addr = state == ST_IDLE ? address : lat_addr;
    src_rd = state == ST_IDLE ? read : lat_rd;
    src_wr = state == ST_IDLE ? write : lat_wr;
    tr_resp = (src_rd && src_wr) ? RESP_SLVERR : dresp;
    rd_word = sel == SEL_INSTR ? imem[idx[IIW-1:0]] : sel == SEL_DATA ? dmem[idx[DIW-1:0]] : '0;
    load = 5'(WAIT_CYCLES - 1) + 5'(extra);
    go_done = state == ST_IDLE ? (req && load == 5'd0) : (state == ST_WAIT && cnt == 5'd1);
    waitrequest = reset || state == ST_WAIT || (state == ST_IDLE && req);
    commit = state == ST_DONE && lat_wr && tr_resp == RESP_OKAY;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_be <= '0;
      lat_rd <= 1'b0;
      lat_wr <= 1'b0;
      readdata <= '0;
      response <= RESP_OKAY;
    end else begin
      readdata <= (go_done && src_rd && tr_resp == RESP_OKAY) ? rd_word : '0;
      response <= go_done ? tr_resp : RESP_OKAY;
      case (state)
        ST_IDLE: if (req) begin
          lat_addr <= address;
          lat_wdata <= writedata;
          lat_be <= byteenable;
          lat_rd <= read;
          lat_wr <= write;
          cnt <= load;
          state <= load == 5'd0 ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (commit)
      for (int i = 0; i < 4; i++)
        if (lat_be[i]) begin
          if (sel == SEL_INSTR) imem[idx[IIW-1:0]][8*i +: 8] <= lat_wdata[8*i +: 8];
          else dmem[idx[DIW-1:0]][8*i +: 8] <= lat_wdata[8*i +: 8];
        end
endmodule

// File: tb/tb_mips_avalon_mem_wait.sv
// tb_mips_avalon_mem_wait: directed self-checking bench for mips_avalon_mem_wait
module tb_mips_avalon_mem_wait;
  import mips_bus_pkg::*;
`ifdef MIPS_MEM_RANDOM_WAIT_EN
  localparam int LMAX = 5;
`else
  localparam int LMAX = 2;
`endif
  localparam int LMIN = 2;
  logic clk = 1'b0, reset = 1'b1, read = 1'b0, write = 1'b0;
  logic [31:0] address = '0, writedata = '0, readdata;
  logic [3:0] byteenable = '0;
  logic waitrequest;
  logic [1:0] response;
  int checks = 0, fails = 0, lat;
  mips_avalon_mem_wait dut (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable), .read(read),
    .write(write), .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata),
    .response(response)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input string tag, input logic [31:0] a, input logic r, input logic w,
                      input logic [3:0] be, input logic [31:0] wd, input logic [1:0] er,
                      input logic [31:0] ed, output int l);
    l = 0;
    @(negedge clk);
    address = a; read = r; write = w; byteenable = be; writedata = wd;
    #1;
    while (waitrequest && l < 20) begin
      chk({tag, "_resp_busy"}, 32'(response), 32'h0);
      l++;
      @(negedge clk);
      #1;
    end
    read = 1'b0; write = 1'b0;
    chk({tag, "_lat"}, 32'(l >= LMIN && l <= LMAX), 32'h1);
    chk({tag, "_resp"}, 32'(response), 32'(er));
    chk({tag, "_rdata"}, readdata, ed);
    @(negedge clk);
    #1;
    chk({tag, "_wr_idle"}, 32'(waitrequest), 32'h0);
    chk({tag, "_resp_idle"}, 32'(response), 32'h0);
  endtask
  initial begin
    logic [15:0] seen;
    #2;
    chk("rst_wait", 32'(waitrequest), 32'h1);
    chk("rst_rdata", readdata, 32'h0);
    chk("rst_resp", 32'(response), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_wait", 32'(waitrequest), 32'h0);
    chk("idle_state", 32'(dut.state), 32'(ST_IDLE));
    xfer("w_instr", 32'hBFC00000, 0, 1, 4'hF, 32'hDEADBEEF, 2'b00, 32'h0, lat);
    xfer("r_instr", 32'hBFC00000, 1, 0, 4'h0, 32'h0, 2'b00, 32'hDEADBEEF, lat);
    xfer("w_full", 32'h00000010, 0, 1, 4'hF, 32'h11223344, 2'b00, 32'h0, lat);
    xfer("w_lanes", 32'h00000010, 0, 1, 4'b0101, 32'hAABBCCDD, 2'b00, 32'h0, lat);
    xfer("r_lanes", 32'h00000010, 1, 0, 4'h0, 32'h0, 2'b00, 32'h11BB33DD, lat);
    xfer("w_be0", 32'h00000010, 0, 1, 4'h0, 32'hFFFFFFFF, 2'b00, 32'h0, lat);
    xfer("r_be0", 32'h00000010, 1, 0, 4'h0, 32'h0, 2'b00, 32'h11BB33DD, lat);
    xfer("w_d0", 32'h00000000, 0, 1, 4'hF, 32'h55AA55AA, 2'b00, 32'h0, lat);
    xfer("r_unmap", 32'h10000000, 1, 0, 4'h0, 32'h0, 2'b11, 32'h0, lat);
    xfer("r_misal", 32'h00000002, 1, 0, 4'h0, 32'h0, 2'b10, 32'h0, lat);
    xfer("w_misal", 32'h00000001, 0, 1, 4'hF, 32'h01234567, 2'b10, 32'h0, lat);
    xfer("r_d0", 32'h00000000, 1, 0, 4'h0, 32'h0, 2'b00, 32'h55AA55AA, lat);
    xfer("w_z20", 32'h00000020, 0, 1, 4'hF, 32'h0, 2'b00, 32'h0, lat);
    xfer("rw_both", 32'h00000020, 1, 1, 4'hF, 32'hFFFFFFFF, 2'b10, 32'h0, lat);
    xfer("r_z20", 32'h00000020, 1, 0, 4'h0, 32'h0, 2'b00, 32'h0, lat);
    xfer("w_iend", 32'hBFC00FFC, 0, 1, 4'hF, 32'h0BADF00D, 2'b00, 32'h0, lat);
    xfer("r_iend", 32'hBFC00FFC, 1, 0, 4'h0, 32'h0, 2'b00, 32'h0BADF00D, lat);
    xfer("r_ipast", 32'hBFC01000, 1, 0, 4'h0, 32'h0, 2'b11, 32'h0, lat);
    xfer("w_dend", 32'h00003FFC, 0, 1, 4'hF, 32'h87654321, 2'b00, 32'h0, lat);
    xfer("r_dend", 32'h00003FFC, 1, 0, 4'h0, 32'h0, 2'b00, 32'h87654321, lat);
    xfer("r_dpast", 32'h00004000, 1, 0, 4'h0, 32'h0, 2'b11, 32'h0, lat);
    xfer("w_40", 32'h00000040, 0, 1, 4'hF, 32'h12345678, 2'b00, 32'h0, lat);
    @(negedge clk);
    address = 32'h00000040; write = 1'b1; byteenable = 4'hF; writedata = 32'hCAFEF00D;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_wait", 32'(waitrequest), 32'h1);
    chk("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    chk("mid_rst_resp", 32'(response), 32'h0);
    chk("mid_rst_rdata", readdata, 32'h0);
    write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_wait", 32'(waitrequest), 32'h0);
    chk("post_rst_state", 32'(dut.state), 32'(ST_IDLE));
    xfer("r_40", 32'h00000040, 1, 0, 4'h0, 32'h0, 2'b00, 32'h12345678, lat);
`ifdef MIPS_MEM_RANDOM_WAIT_EN
    seen = '0;
    for (int i = 0; i < 1000; i++) begin
      if (i[0]) xfer("rnd_i", 32'hBFC00000, 1, 0, 4'h0, 32'h0, 2'b00, 32'hDEADBEEF, lat);
      else xfer("rnd_d", 32'h00000000, 1, 0, 4'h0, 32'h0, 2'b00, 32'h55AA55AA, lat);
      if (lat < 16) seen[lat] = 1'b1;
    end
    chk("rnd_distinct", 32'($countones(seen) >= 3), 32'h1);
`else
    seen = '0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
